// File: rtl/speck_stream_frontend.sv
// speck_stream_frontend: assembles key/plaintext from a byte stream, starts the SPECK
// controller, then streams the captured ciphertext back out byte by byte.
module speck_stream_frontend #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] key,
    output logic [127:0] plaintext,
    output logic         start,
    input  logic         finished,
    input  logic [127:0] ciphertext,
    output logic         busy,
    output logic         timeout_err
);
    typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_t;

    state_t       r_state;
    logic [4:0]   r_cnt;
    logic [15:0]  r_timer;
    logic [127:0] r_key;
    logic [127:0] r_pt;
    logic [127:0] r_sh;
    logic         r_start;
    logic         r_terr;

    assign in_ready    = r_state == LOAD;
    assign out_valid   = r_state == SEND;
    assign busy        = r_state != LOAD;
    assign out_data    = r_sh[127:120];
    assign key         = r_key;
    assign plaintext   = r_pt;
    assign start       = r_start;
    assign timeout_err = r_terr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
            r_cnt   <= 5'd0;
            r_timer <= 16'd0;
            r_key   <= 128'd0;
            r_pt    <= 128'd0;
            r_sh    <= 128'd0;
            r_start <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                LOAD: if (in_valid) begin
                    // key and plaintext form one 256-bit shift register, first byte ends in key MSB
                    {r_key, r_pt} <= {r_key[119:0], r_pt, in_data};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd0) r_terr <= 1'b0;
                    if (r_cnt == 5'd31) begin
                        r_state <= START;
                        r_start <= 1'b1;
                    end
                end
                START: begin
                    r_timer <= 16'd0;
                    r_state <= WAIT;
                end
                WAIT: if (finished) begin
                    r_sh    <= ciphertext;
                    r_state <= SEND;
                end else if (r_timer == 16'(TIMEOUT_CYCLES - 1)) begin
                    r_terr  <= 1'b1;
                    r_state <= LOAD;
                end else begin
                    r_timer <= r_timer + 16'd1;
                end
                SEND: if (out_ready) begin
                    r_sh  <= {r_sh[119:0], 8'd0};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd15) begin
                        r_cnt   <= 5'd0;
                        r_state <= LOAD;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_speck_stream_frontend.sv
// tb_speck_stream_frontend: randomized and directed runs of the frontend against a
// byte-queue reference model and an XOR stub controller.
module tb_speck_stream_frontend;
    localparam int TO = 48;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [7:0]   in_data = 8'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         start;
    logic         finished = 1'b0;
    logic [127:0] ciphertext = 128'd0;
    logic         busy;
    logic         timeout_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stub_cnt = 0;
    int stub_lat = 0;
    int starts, start_cyc, last_acc_cyc, first_ov_cyc;
    bit ov_seen;
    logic [127:0] stub_ct = 128'd0;
    logic [7:0] acc_in[$];
    logic [7:0] got_out[$];

    speck_stream_frontend #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .key(key),
        .plaintext(plaintext), .start(start), .finished(finished), .ciphertext(ciphertext),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: log handshakes seen before the edge, then advance the stub controller.
    task automatic step();
        bit acc, stall;
        logic [7:0] held;
        acc = in_valid && in_ready;
        if (acc) acc_in.push_back(in_data);
        if (out_valid && out_ready) got_out.push_back(out_data);
        stall = out_valid && !out_ready;
        held = out_data;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) last_acc_cyc = cyc;
        if (stall) chk("stall_hold", {out_valid, out_data}, {1'b1, held});
        if (out_valid && !ov_seen) begin
            ov_seen = 1'b1;
            first_ov_cyc = cyc;
        end
        if (start) begin
            starts++;
            start_cyc = cyc;
            stub_cnt = stub_lat;
            stub_ct = key ^ plaintext;
            finished = 1'b0;
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            finished = stub_cnt == 0;
        end else begin
            finished = 1'b0;
        end
        ciphertext = finished ? stub_ct : {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        finished = 1'b0;
        stub_cnt = 0;
        #2;
        chk("rst_ctl", {start, out_valid, in_ready, busy, timeout_err, out_data}, {5'b00100, 8'h00});
        chk("rst_kp", {key, plaintext}, 256'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run(input int lat, input bit bp, input bit stray, input bit nominal,
                       input int rst_in, input int rst_out);
        logic [255:0] nom;
        logic [255:0] kp;
        logic [127:0] exp_ct, got;
        logic [7:0] b[32];
        int budget, idx;
        nom = 256'h0f0e0d0c0b0a09080706050403020100_6c617669757165207469206564616d20;
        kp = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = nominal ? nom[255 - 8 * i -: 8] : 8'($urandom);
            kp = {kp[247:0], b[i]};
        end
        acc_in.delete();
        got_out.delete();
        starts = 0;
        ov_seen = 1'b0;
        stub_lat = lat;
        start_cyc = -1;
        first_ov_cyc = -1;
        last_acc_cyc = -1;
        budget = 0;
        while (budget < 2000) begin
            idx = acc_in.size();
            in_valid = idx < 32 ? (!bp || $urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            in_data = idx < 32 ? b[idx] : 8'($urandom);
            out_ready = !bp || $urandom_range(0, 2) != 0;
            if (stray && starts == 0) finished = 1'($urandom_range(0, 1));
            if (stray && starts == 1 && cyc == start_cyc) finished = 1'b1;
            step();
            budget++;
            if (acc_in.size() == 1 && last_acc_cyc == cyc) chk("terr_clear", timeout_err, 0);
            if (rst_in > 0 && acc_in.size() == rst_in) break;
            if (rst_out > 0 && got_out.size() == rst_out) break;
            if (got_out.size() == 16 || (starts > 0 && !busy)) break;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        finished = 1'b0;
        if (rst_in > 0 || rst_out > 0) return;
        chk("in_budget", budget < 2000, 1);
        chk("in_count", acc_in.size(), 32);
        chk("key", key, kp[255:128]);
        chk("plaintext", plaintext, kp[127:0]);
        chk("start_once", starts, 1);
        chk("start_cycle", start_cyc, last_acc_cyc);
        if (lat > 0 && lat <= TO) begin
            exp_ct = kp[255:128] ^ kp[127:0];
            got = '0;
            foreach (got_out[i]) got = {got[119:0], got_out[i]};
            chk("out_count", got_out.size(), 16);
            chk("out_bytes", got, exp_ct);
            if (nominal) chk("nom_out", got, 128'h636f7b657e7b6c28736f256167636c20);
            chk("send_rise", first_ov_cyc, start_cyc + lat + 1);
            if (!bp) chk("send_len", cyc, first_ov_cyc + 16);
            chk("terr_low", timeout_err, 0);
        end else begin
            chk("terr_high", timeout_err, 1);
            chk("no_output", ov_seen, 0);
            chk("wait_len", cyc, start_cyc + TO + 1);
        end
        chk("idle_ctl", {busy, in_ready, out_valid, start}, 4'b0100);
    endtask

    initial begin
        do_reset();
        run(40, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) run($urandom_range(1, TO), 1, 0, 0, 0, 0);
        run(1, 1, 0, 0, 0, 0);
        run(40, 0, 1, 1, 0, 0);
        run(25, 1, 1, 0, 0, 0);
        run(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        chk("terr_sticky", timeout_err, 1);
        run(20, 1, 0, 0, 0, 0);
        run(TO, 0, 0, 0, 0, 0);
        run(TO + 1, 0, 0, 0, 0, 0);
        run(12, 1, 0, 0, 0, 0);
        run(30, 0, 0, 0, 20, 0);
        do_reset();
        run(40, 0, 0, 1, 0, 0);
        run(15, 0, 0, 0, 0, 7);
        chk("pre_rst_ov", out_valid, 1);
        do_reset();
        ov_seen = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
        out_ready = 1'b0;
        chk("post_rst_quiet", ov_seen, 0);
        chk("post_rst_count", got_out.size(), 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/speck_stream_frontend.md
# speck_stream_frontend

Byte-serial front end for the SPECK128/128 cipher controller. It assembles a 16-byte key and a 16-byte plaintext from a valid/ready byte stream and issues a one-cycle `start` to the controller. It then waits for the controller's `finished`, captures the 128-bit ciphertext and streams it back out as 16 bytes over a second valid/ready port. A timeout guards against a controller that never finishes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: WAIT-state cycles allowed before abort; legal range 1..65535.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_data`  in  8  input byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `out_data`  out  8  ciphertext byte.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  sink accepts `out_data` this cycle.
- `key`  out  128  to controller `key`.
- `plaintext`  out  128  to controller `plaintext`.
- `start`  out  1  to controller `start`; one-cycle pulse.
- `finished`  in  1  from controller `finished`.
- `ciphertext`  in  128  from controller `ciphertext`.
- `busy`  out  1  high in START, WAIT and SEND.
- `timeout_err`  out  1  sticky timeout flag.

## Operation
- States: LOAD, START, WAIT, SEND.
- Byte counter: 5 bits. WAIT timer: 16 bits.
- **Reset** (`rst_n`=0, any state):
  - State goes to LOAD; counter and timer go to 0.
  - `key`, `plaintext` and the output shift register go to 0.
  - `start`=0, `out_valid`=0, `in_ready`=1 (follows LOAD), `busy`=0, `timeout_err`=0, `out_data`=0.
  - A reset mid-transfer or mid-encryption discards all data.
- **LOAD:**
  - `in_ready`=1.
  - Each accepted byte (`in_valid`&`in_ready`) shifts left into the 256-bit concatenation {`key`,`plaintext`}.
  - Result: byte 0 ends in `key[127:120]`, byte 15 in `key[7:0]`, byte 16 in `plaintext[127:120]`, byte 31 in `plaintext[7:0]`.
  - Counter increments per accepted byte. On acceptance of byte 31, counter returns to 0 and state goes to START.
  - Accepting byte 0 clears `timeout_err`.
- **START:**
  - `start`=1 for exactly this one cycle.
  - Timer is cleared; next state is WAIT.
  - `key` and `plaintext` are held constant from the end of LOAD until the next byte is accepted in LOAD.
- **WAIT:**
  - `finished` is sampled only in WAIT, never in START.
  - `finished`=1: load `ciphertext` into the output shift register, go to SEND.
  - Otherwise the timer increments. When the timer reaches `TIMEOUT_CYCLES`-1 with `finished` still 0: set `timeout_err`=1 and go to LOAD. No output bytes are produced.
  - `finished` and timeout expiry in the same cycle: `finished` wins.
- **SEND:**
  - `out_valid`=1; `out_data` = shift register `[127:120]`.
  - On `out_valid`&`out_ready`: shift left by 8 and increment the counter.
  - On the 16th accepted byte, counter returns to 0 and state goes to LOAD.
  - `out_data` and `out_valid` stay stable while `out_ready`=0.
- `in_ready`=0 outside LOAD. Input bytes presented outside LOAD are not consumed.
- `finished` arriving outside WAIT is ignored.

## Timing
- `in_ready`, `out_valid` and `busy` decode combinationally from the state register.
- `start`, `key`, `plaintext`, `out_data` and `timeout_err` are registered.
- Let byte 31 be accepted at edge N. Then `start`=1 in cycle N..N+1, and WAIT begins at edge N+1.
- Let `finished`=1 be sampled at edge M. Then `out_valid`=1 from M onward, with `out_data` = `ciphertext[127:120]`.
- With `in_valid` and `out_ready` held high:
  - Input: 32 cycles.
  - Start/wait: 1 + controller latency.
  - Output: 16 cycles.
  - Return to LOAD immediately after the 16th output byte; the next input byte may be accepted in the following cycle.
- Timeout: at most `TIMEOUT_CYCLES` WAIT cycles. `timeout_err` rises on the same edge that enters LOAD.
- `finished` may be a single-cycle pulse; it must be captured when present in any WAIT cycle.

## Test plan
- **Reset values:** reset asserted → all outputs at reset values, `in_ready`=1, `busy`=0.
- **Nominal run:**
  - Stimulus: stream bytes 0x0F,0x0E,…,0x00 then 0x6C,0x61,0x76,0x69,0x75,0x71,0x65,0x20,0x74,0x69,0x20,0x65,0x64,0x61,0x6D,0x20.
  - Required: `key`=0x0f0e0d0c0b0a09080706050403020100 and `plaintext`=0x6c617669757165207469206564616d20.
  - Required: exactly one `start` pulse, the cycle after the last byte.
  - A stub controller returns `ciphertext`=`plaintext`^`key` with `finished` after 40 cycles. Required: out bytes 0x63,0x6F,0x7B,0x65,0x7E,0x7B,0x6C,0x28,0x73,0x6F,0x25,0x61,0x67,0x63,0x6C,0x20 in order.
- **Backpressure:**
  - Random `in_valid` gaps and `out_ready` stalls → identical bytes out.
  - `out_data` is stable during each stall.
  - No byte is duplicated or dropped.
- **Timeout:**
  - Stub never asserts `finished`, `TIMEOUT_CYCLES`=10 → `timeout_err`=1 after 10 WAIT cycles.
  - State returns to LOAD with no `out_valid`.
  - The next accepted byte clears `timeout_err`.
- **Stray/edge `finished`:**
  - `finished` pulsed during LOAD or START → ignored.
  - `finished` on the exact expiry cycle → SEND, `timeout_err`=0.
- **Reset mid-op:**
  - `rst_n` pulsed low at input byte 20 → restart from byte 0.
  - `rst_n` pulsed low at output byte 7 → `out_valid` drops immediately and there is no further output.
